// File: rtl/dac_sample_scheduler.sv
// Sample-rate controller: mixes one sample per enabled voice each tick, saturates,
// and hands the offset-binary word to the DAC driver over valid/ready.
module dac_sample_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int CLK_DIV = 2268
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [16*NUM_SRC-1:0]  src_data,
  input  logic [NUM_SRC-1:0]     src_valid,
  output logic [NUM_SRC-1:0]     src_ready,
  input  logic [NUM_SRC-1:0]     src_enable,
  output logic [15:0]            dac_data,
  output logic                   dac_valid,
  input  logic                   dac_ready,
  output logic                   sample_tick,
  output logic [NUM_SRC-1:0]     underrun,
  output logic                   overrun,
  input  logic                   clear_status
);

  localparam int AW = (16 + $clog2(NUM_SRC) < 17) ? 17 : 16 + $clog2(NUM_SRC);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

  typedef enum logic [1:0] {IDLE, GATHER, SEND} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         tick_cnt;
  logic [IW-1:0]         idx, idx_n;
  logic signed [AW-1:0]  acc, acc_n, acc_sum, slot_ext;
  logic [15:0]           slot_sample, sat, data_n;
  logic                  slot_take;
  logic [NUM_SRC-1:0]    unr_set;
  logic                  ovr_set;

  // The counter free-runs regardless of the frame state; the tick is registered
  // one count early so it lines up with counter == CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
    end else begin
      tick_cnt    <= (tick_cnt == CW'(CLK_DIV - 1)) ? '0 : tick_cnt + CW'(1);
      sample_tick <= (tick_cnt == CW'(CLK_DIV - 2));
    end
  end

  always_comb begin
    slot_sample = src_data[16*idx +: 16];
    slot_take   = src_enable[idx] && src_valid[idx];
    slot_ext    = slot_take ? {{(AW-16){slot_sample[15]}}, slot_sample} : '0;
    acc_sum     = acc + slot_ext;
    if (acc_sum > SAT_MAX)      sat = 16'h7FFF;
    else if (acc_sum < SAT_MIN) sat = 16'h8000;
    else                        sat = acc_sum[15:0];
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    acc_n     = acc;
    data_n    = dac_data;
    unr_set   = '0;
    ovr_set   = 1'b0;
    src_ready = '0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          state_n = GATHER;
          idx_n   = '0;
          acc_n   = '0;
        end
      end
      GATHER: begin
        src_ready[idx] = src_enable[idx];
        acc_n          = acc_sum;
        if (src_enable[idx] && !src_valid[idx]) unr_set[idx] = 1'b1;
        if (idx == IW'(NUM_SRC - 1)) begin
          state_n = SEND;
          data_n  = {~sat[15], sat[14:0]};
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      SEND: begin
        // A tick coinciding with the handshake starts the next frame directly.
        if (dac_ready) begin
          if (sample_tick) begin
            state_n = GATHER;
            idx_n   = '0;
            acc_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else if (sample_tick) begin
          ovr_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // A flag raised in the same cycle as clear_status survives the clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx      <= '0;
      acc      <= '0;
      dac_data <= 16'h8000;
      underrun <= '0;
      overrun  <= 1'b0;
    end else begin
      idx      <= idx_n;
      acc      <= acc_n;
      dac_data <= data_n;
      underrun <= (clear_status ? '0 : underrun) | unr_set;
      overrun  <= (overrun & ~clear_status) | ovr_set;
    end
  end

  assign dac_valid = (state == SEND);

endmodule

// File: doc/dac_sample_scheduler.md
Name: dac_sample_scheduler

Overview:
Sample-rate controller sitting in front of the pmodda3 serial DAC driver. It generates the audio sample tick. On each tick it collects one signed 16-bit sample from each enabled voice source in fixed index order, sums them with saturation, and converts the result to offset binary. It then presents that single word to the DAC driver over a valid/ready handshake, and flags per-source underrun and DAC overrun.

Parameters:
NUM_SRC, 4, number of voice sources (1..8)
CLK_DIV, 2268, clk cycles per sample tick; must be >= NUM_SRC+2

Ports:
clk  input  1  system clock
rstn  input  1  synchronous active-low reset
src_data  input  16*NUM_SRC  signed two's-complement samples; source i at bits [16*i+15:16*i]
src_valid  input  NUM_SRC  per-source sample valid
src_ready  output  NUM_SRC  per-source accept strobe
src_enable  input  NUM_SRC  per-source mix enable
dac_data  output  16  offset-binary word to DAC driver
dac_valid  output  1  word valid to DAC driver
dac_ready  input  1  DAC driver ready
sample_tick  output  1  one-cycle pulse at each sample period
underrun  output  NUM_SRC  sticky: source enabled but not valid at its slot
overrun  output  1  sticky: tick arrived while previous word not yet accepted
clear_status  input  1  clears underrun/overrun

Behaviour:
- Reset (rstn=0 at posedge): state IDLE, tick counter 0, acc 0, dac_valid 0, dac_data 16'h8000 (midscale), sample_tick 0, underrun 0, overrun 0. src_ready is 0 whenever not in GATHER.
- Reset mid-frame abandons the frame. dac_valid is 0 the cycle after reset.
- Tick counter: counts 0..CLK_DIV-1 and wraps. sample_tick is registered, high for the cycle where counter==CLK_DIV-1. The counter free-runs in all states.
- States are IDLE, GATHER, SEND.
- IDLE: when sample_tick=1, go to GATHER with idx=0 and acc=0.
- GATHER: one cycle per source, idx=0..NUM_SRC-1. src_ready[i] is combinational and high only when state==GATHER && idx==i && src_enable[i].
  - Enabled and valid: add sign-extended sample to acc.
  - Enabled and not valid: add 0 and set underrun[i].
  - Disabled: add 0, no flag, src_ready[i] stays low.
  - After idx==NUM_SRC-1, go to SEND.
- acc width is 16+clog2(NUM_SRC) bits (min 17), signed. It clamps to [-32768, 32767]. The result is registered into dac_data with bit 15 inverted (offset binary) on entry to SEND.
- SEND: dac_valid=1 with dac_data held stable until dac_valid&&dac_ready, then dac_valid=0 the next cycle.
  - If sample_tick is also high in the handshake cycle, go straight to GATHER (no overrun).
  - Otherwise go to IDLE.
- Latency: tick in cycle T; GATHER occupies cycles T+1..T+NUM_SRC; dac_valid first high in cycle T+NUM_SRC+1.
- Tick while in SEND without handshake in that cycle: set overrun and drop the tick. The current word stays presented, and no new frame starts until a later tick.
- dac_data keeps the last sent value after the handshake.
- clear_status=1 zeroes underrun/overrun next cycle. A flag set in the same cycle wins (the flag remains 1).
- src_valid and src_enable are sampled only in the relevant GATHER slot. Changes at other times have no effect.

Test Plan:
(NUM_SRC=4, CLK_DIV=16, dac_ready tied 1 unless stated)
1. Reset release -> dac_data=16'h8000, dac_valid=0, src_ready=0. First sample_tick is on the 16th cycle after release, then every 16 cycles. dac_valid is first high 5 cycles after the tick.
2. Sources 16'h1000, 16'h0200, 16'hFFFF, 16'h0000, all enabled and valid -> each src_ready[i] pulses once, in order 0..3, on consecutive cycles. dac_data=16'h91FF for one cycle; underrun=0.
3. Saturation: all four = 16'h7000 -> dac_data=16'hFFFF. All four = 16'h9000 -> dac_data=16'h0000. Mixed 16'h7FFF, 16'h8000, 0, 0 -> 16'h7FFF.
4. src_valid[2]=0, src_enable[3]=0 with src_valid[3]=1, others 16'h0100 -> dac_data=16'h8200, underrun=4'b0100, src_ready[3] never high. The flag persists until clear_status. clear_status and a new underrun in the same cycle -> the flag stays 1.
5. dac_ready held 0 for 40 cycles -> dac_valid stays 1 with constant dac_data and overrun=1 after the next tick. Releasing dac_ready gives one handshake. The next frame starts only at a subsequent tick. Tick coincident with the handshake -> GATHER starts the next cycle, overrun not set.
6. rstn pulsed low during GATHER (idx=2) -> no src_ready after reset. dac_valid=0, dac_data=16'h8000, the tick counter restarts at 0, and the first tick comes 16 cycles after release.
